// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared constants and state encoding for the sequential divider
package seq_divider_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int STEP_COUNT = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring division iteration, MSB first
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  // The trial remainder carries one extra bit so the compare cannot overflow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvsr_ext;
  logic           ge;

  assign shifted  = {rem_i, q_i[WIDTH-1]};
  assign dvsr_ext = {1'b0, dvsr_i};
  assign ge       = (shifted >= dvsr_ext);
  assign rem_o    = ge ? WIDTH'(shifted - dvsr_ext) : shifted[WIDTH-1:0];
  assign q_o      = {q_i[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multicycle signed divider (DIV): quotient to LO, remainder to HI
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(STEP_COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_COUNT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .q_i    (q_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    q_d       = q_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            done_d = 1'b1;
            div0_d = 1'b1;
          end else begin
            // The quotient register starts out holding the dividend magnitude and shifts into rem.
            q_d       = dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_d    = divisor[WIDTH-1] ? -divisor : divisor;
            rem_d     = '0;
            cnt_d     = '0;
            quo_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg_d = dividend[WIDTH-1];
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        lo_d    = quo_neg_q ? -q_q : q_q;
        hi_d    = rem_neg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      q_q       <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign div0   = div0_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
